axi4_write_slave: RTL and testbench

AXI4-Full write-channel responder (AW/W/B only) that terminates bursts from the DMA write master and drives a word-addressed, byte-enabled memory write port (BRAM front end). It accepts one burst at a time: an address handshake, then exactly AWLEN+1 data beats, then one write response. Unsupported or out-of-range bursts are fully drained and answered with SLVERR, without any memory write.

---
 rtl/axi4_write_slave.sv | 147 ++++++++++++++
 tb/tb_axi4_write_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_slave.sv
// AXI4 write-channel responder (AW/W/B) driving a word-addressed, byte-enabled memory write port.
// Latency: 1 cycle AW->W, 1 cycle last W->B, 1 cycle B->AW; bad bursts are drained and answered SLVERR.
module axi4_write_slave #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_MEM_ADDR_WIDTH   = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic                          mem_we,
    output logic [C_MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]                    mem_wstrb,
    output logic [15:0]                   o_burst_cnt
);

    localparam logic [32:0] MEM_BYTES = 33'd4 << C_MEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        W_DATA = 3'b010,
        B_RESP = 3'b100
    } state_t;

    state_t                      state;
    logic [7:0]                  r_len;
    logic [7:0]                  beat_cnt;
    logic                        r_err;
    logic                        r_err_aw;
    logic                        r_incr;
    logic [C_MEM_ADDR_WIDTH-1:0] word_addr;

    logic [32:0] aw_off;
    logic [32:0] aw_end;
    logic        aw_bad;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        last_beat;
    logic        wlast_bad;

    // 33-bit offset/end so neither a high awaddr nor a long burst can wrap past the size check
    always_comb begin
        aw_off = {1'b0, s_axi_awaddr} - {1'b0, C_BASE_ADDR};
        aw_end = aw_off + ((33'(s_axi_awlen) + 33'd1) << 2);
        aw_bad = (s_axi_awsize != 3'b010)
               | s_axi_awburst[1]
               | (s_axi_awaddr[1:0] != 2'b00)
               | (s_axi_awaddr < C_BASE_ADDR)
               | (aw_end > MEM_BYTES);
    end

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign b_hs      = s_axi_bvalid & s_axi_bready;
    assign last_beat = (beat_cnt == r_len);
    assign wlast_bad = (s_axi_wlast != last_beat);

    assign mem_we    = w_hs & ~r_err_aw;
    assign mem_addr  = word_addr;
    assign mem_wdata = s_axi_wdata;
    assign mem_wstrb = s_axi_wstrb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            r_len         <= '0;
            beat_cnt      <= '0;
            r_err         <= 1'b0;
            r_err_aw      <= 1'b0;
            r_incr        <= 1'b0;
            word_addr     <= '0;
            o_burst_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (aw_hs) begin
                        state         <= W_DATA;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        r_len         <= s_axi_awlen;
                        beat_cnt      <= '0;
                        r_err         <= aw_bad;
                        r_err_aw      <= aw_bad;
                        r_incr        <= (s_axi_awburst == 2'b01);
                        word_addr     <= aw_off[C_MEM_ADDR_WIDTH+1:2];
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (r_incr) begin
                            word_addr <= word_addr + 1'b1;
                        end
                        if (wlast_bad) begin
                            r_err <= 1'b1;
                        end
                        // awlen alone ends the burst; wlast only feeds the error flag
                        if (last_beat) begin
                            state        <= B_RESP;
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (r_err | wlast_bad) ? 2'b10 : 2'b00;
                        end
                    end
                end
                B_RESP: begin
                    if (b_hs) begin
                        state         <= IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= 2'b00;
                        s_axi_awready <= 1'b1;
                        o_burst_cnt   <= o_burst_cnt + 16'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    s_axi_bresp   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_write_slave.sv
// Bench for axi4_write_slave: table of bursts plus hand-written corner sequences, scoreboarded memory writes and responses.
module tb_axi4_write_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] o_burst_cnt;

    axi4_write_slave dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .o_burst_cnt(o_burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        int          bad;
        logic [1:0]  resp;
        bit          we;
    } vec_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    vec_t        vt[12];
    wr_t         wq[$];
    logic [1:0]  rq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    logic        prev_bv = 1'b0;
    logic        prev_br = 1'b0;
    logic [1:0]  prev_resp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_bv <= 1'b0;
            prev_br <= 1'b0;
        end else begin
            if (mem_we) begin
                chk("we_with_wvalid", {63'd0, s_axi_wvalid}, 64'd1);
                if (wq.size() == 0) begin
                    chk("unexpected_write", {54'd0, mem_addr}, 64'hFFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("mem_write", {18'd0, mem_addr, mem_wdata, mem_wstrb},
                        {18'd0, e.a, e.d, e.s});
                end
            end
            if (prev_bv && !prev_br) begin
                chk("b_hold", {61'd0, s_axi_bvalid, s_axi_bresp}, {61'd0, 1'b1, prev_resp});
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (rq.size() == 0) begin
                    chk("unexpected_b", {62'd0, s_axi_bresp}, 64'hFF);
                end else begin
                    logic [1:0] r;
                    r = rq.pop_front();
                    chk("bresp", {62'd0, s_axi_bresp}, {62'd0, r});
                end
            end
            prev_bv   <= s_axi_bvalid;
            prev_br   <= s_axi_bready;
            prev_resp <= s_axi_bresp;
        end
    end

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awsize  = size;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!s_axi_awready) begin
            chk("aw_timeout", 64'd0, 64'd1);
            s_axi_awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        chk("aw_to_wready", {62'd0, s_axi_awready, s_axi_wready}, 64'd1);
    endtask

    task automatic do_w(input logic [7:0] len, input int bad, input logic [3:0] strb,
                        input logic [31:0] dbase, input bit rnd, input bit we,
                        input logic [9:0] waddr, input bit incr);
        logic [9:0] a = waddr;
        for (int i = 0; i <= int'(len); i++) begin
            int t = 0;
            if (rnd) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_axi_wvalid = 1'b0;
                    s_axi_wdata  = $urandom;
                    @(posedge clk); #1;
                end
            end
            s_axi_wdata  = rnd ? $urandom : dbase + 32'(i);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == int'(len)) ^ (i == bad);
            s_axi_wvalid = 1'b1;
            while (!s_axi_wready && t < 50) begin
                @(posedge clk); #1; t++;
            end
            if (!s_axi_wready) begin
                chk("w_timeout", 64'd0, 64'd1);
                s_axi_wvalid = 1'b0;
                return;
            end
            if (we) wq.push_back('{a, s_axi_wdata, strb});
            if (incr) a = a + 10'd1;
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk("w_to_bvalid", {62'd0, s_axi_bvalid, s_axi_wready}, 64'd2);
    endtask

    task automatic do_b(input logic [1:0] resp, input bit rnd);
        int t = 0;
        rq.push_back(resp);
        s_axi_bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(s_axi_bvalid && s_axi_bready) && t < 200) begin
            @(posedge clk); #1; t++;
            s_axi_bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!(s_axi_bvalid && s_axi_bready)) begin
            chk("b_timeout", 64'd0, 64'd1);
            s_axi_bready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("b_to_awready", {63'd0, s_axi_awready}, 64'd1);
        chk("burst_cnt", {48'd0, o_burst_cnt}, {48'd0, exp_cnt});
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {55'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, mem_we, 2'b00},
            64'd0);
        chk({name, "_cnt"}, {48'd0, o_burst_cnt}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        //        addr           len    size    burst  strb   bad  resp   we
        vt[0]  = '{32'h0000_0010, 8'd3, 3'b010, 2'b01, 4'hF, -1, 2'b00, 1'b1};
        vt[1]  = '{32'h0000_0020, 8'd2, 3'b010, 2'b00, 4'h3, -1, 2'b00, 1'b1};
        vt[2]  = '{32'h0000_0FF4, 8'd3, 3'b010, 2'b01, 4'hF, -1, 2'b10, 1'b0};
        vt[3]  = '{32'h0000_0000, 8'd0, 3'b011, 2'b01, 4'hF, -1, 2'b10, 1'b0};
        vt[4]  = '{32'h0000_0040, 8'd0, 3'b010, 2'b01, 4'hF, -1, 2'b00, 1'b1};
        vt[5]  = '{32'h0000_0100, 8'd3, 3'b010, 2'b01, 4'hF,  1, 2'b10, 1'b1};
        vt[6]  = '{32'h0000_0FF0, 8'd3, 3'b010, 2'b01, 4'hC, -1, 2'b00, 1'b1};
        vt[7]  = '{32'h0000_0030, 8'd1, 3'b010, 2'b10, 4'hF, -1, 2'b10, 1'b0};
        vt[8]  = '{32'h0000_0002, 8'd0, 3'b010, 2'b01, 4'hF, -1, 2'b10, 1'b0};
        vt[9]  = '{32'h0000_0200, 8'd1, 3'b010, 2'b01, 4'hF,  1, 2'b10, 1'b1};
        vt[10] = '{32'h0000_0080, 8'd1, 3'b010, 2'b01, 4'h0, -1, 2'b00, 1'b1};
        vt[11] = '{32'hFFFF_FFF0, 8'd3, 3'b010, 2'b01, 4'hF, -1, 2'b10, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        chk("awready_before_edge", {63'd0, s_axi_awready}, 64'd0);
        @(posedge clk); #1;
        chk("awready_after_release", {63'd0, s_axi_awready}, 64'd1);

        // data before address is stalled
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = 32'hDEAD_BEEF;
        repeat (2) begin
            chk("wready_in_idle", {63'd0, s_axi_wready}, 64'd0);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;

        for (int v = 0; v < 12; v++) begin
            do_aw(vt[v].addr, vt[v].len, vt[v].size, vt[v].burst);
            do_w(vt[v].len, vt[v].bad, vt[v].strb, 32'h0A0 | (32'(v) << 12), 1'b0, vt[v].we,
                 vt[v].addr[11:2], vt[v].burst == 2'b01);
            do_b(vt[v].resp, 1'b0);
        end

        for (int k = 0; k < 2; k++) begin
            do_aw(32'h0000_0000, 8'd255, 3'b010, 2'b01);
            do_w(8'd255, -1, 4'hF, 32'h0, 1'b1, 1'b1, 10'd0, 1'b1);
            do_b(2'b00, 1'b1);
        end

        // awvalid during W_DATA stays un-acked, then reset mid-burst
        do_aw(32'h0000_0200, 8'd7, 3'b010, 2'b01);
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_axi_wdata  = 32'h5500 + 32'(i);
            s_axi_wstrb  = 4'hF;
            s_axi_wvalid = 1'b1;
            chk("awready_in_wdata", {63'd0, s_axi_awready}, 64'd0);
            wq.push_back('{10'h080 + 10'(i), s_axi_wdata, 4'hF});
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("partial_writes_seen", 64'(wq.size()), 64'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        wq.delete();
        rq.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_aw(32'h0000_0300, 8'd1, 3'b010, 2'b01);
        do_w(8'd1, -1, 4'hF, 32'h7700, 1'b0, 1'b1, 10'h0C0, 1'b1);
        do_b(2'b00, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
        chk("resp_queue_empty", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
